// File: rtl/rec_fp_pkg.sv
// rtl/rec_fp_pkg.sv - shared constants, class enum and width helper for double-to-recoded-float conversion
package rec_fp_pkg;

  localparam int DBL_W      = 64;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;
  localparam int DBL_BIAS   = 1023;

  // Wide enough for the rebiased exponent of any double plus a rounding carry
  localparam int ES_W = 13;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  localparam logic [2:0] REC_ZERO = 3'b000;
  localparam logic [2:0] REC_INF  = 3'b110;
  localparam logic [2:0] REC_NAN  = 3'b111;

  function automatic int rec_width(input int exp_w, input int sig_w);
    return exp_w + sig_w + 1;
  endfunction

endpackage

// File: rtl/rec_fp_round.sv
// rtl/rec_fp_round.sv - round-to-nearest-even, carry, flush and overflow saturation into the recoded word
module rec_fp_round
  import rec_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24
) (
  input  logic                               sign,
  input  fp_class_e                          cls,
  input  logic [ES_W-1:0]                    es,
  input  logic [SIG_W-2:0]                   frac,
  input  logic                               guard,
  input  logic                               sticky,
  output logic [rec_width(EXP_W,SIG_W)-1:0]  data,
  output logic [2:0]                         flags
);

  localparam int              OUT_W   = rec_width(EXP_W, SIG_W);
  localparam int              FRAC_W  = SIG_W - 1;
  localparam logic [ES_W-1:0] ES_OVF  = ES_W'((1 << EXP_W) - 1);
  localparam logic [EXP_W:0]  REC_OFS = (EXP_W+1)'((1 << (EXP_W - 1)) + 1);

  logic              round_up;
  logic              carry;
  logic              inexact;
  logic              es_nonpos;
  logic [FRAC_W-1:0] frac_rnd;
  logic [ES_W-1:0]   es_rnd;
  logic [EXP_W:0]    rec_exp;
  logic [EXP_W:0]    exp_zero;
  logic [EXP_W:0]    exp_inf;
  logic [EXP_W:0]    exp_nan;
  logic [FRAC_W-1:0] frac_nan;

  assign exp_zero = {REC_ZERO, {(EXP_W-2){1'b0}}};
  assign exp_inf  = {REC_INF,  {(EXP_W-2){1'b0}}};
  assign exp_nan  = {REC_NAN,  {(EXP_W-2){1'b0}}};
  assign frac_nan = {1'b1, {(FRAC_W-1){1'b0}}};

  always_comb begin
    round_up            = guard & (sticky | frac[0]);
    {carry, frac_rnd}   = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    es_rnd              = es + {{(ES_W-1){1'b0}}, carry};
    inexact             = guard | sticky;
    // es is two's complement; zero or negative means below the minimum normal
    es_nonpos           = es[ES_W-1] | (es == '0);
    rec_exp             = es_rnd[EXP_W:0] + REC_OFS;

    data                = '0;
    data[OUT_W-1]       = sign;
    flags               = 3'b000;

    case (cls)
      NAN: begin
        data[OUT_W-2 -: EXP_W+1] = exp_nan;
        data[FRAC_W-1:0]         = frac_nan;
      end
      INF: begin
        data[OUT_W-2 -: EXP_W+1] = exp_inf;
      end
      ZERO: begin
        data[OUT_W-2 -: EXP_W+1] = exp_zero;
        flags                    = {1'b0, inexact, inexact};
      end
      default: begin
        if (es_nonpos) begin
          data[OUT_W-2 -: EXP_W+1] = exp_zero;
          flags                    = 3'b011;
        end else if (es_rnd >= ES_OVF) begin
          data[OUT_W-2 -: EXP_W+1] = exp_inf;
          flags                    = 3'b101;
        end else begin
          data[OUT_W-2 -: EXP_W+1] = rec_exp;
          data[FRAC_W-1:0]         = frac_rnd;
          flags                    = {2'b00, inexact};
        end
      end
    endcase
  end

endmodule

// File: rtl/dbl_to_rec_fp.sv
// rtl/dbl_to_rec_fp.sv - two-stage valid/ready pipeline converting IEEE-754 double bits to recoded float
module dbl_to_rec_fp
  import rec_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DBL_W-1:0]                   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [rec_width(EXP_W,SIG_W)-1:0]  out_data,
  output logic [2:0]                         out_flags
);

  localparam int              OUT_W  = rec_width(EXP_W, SIG_W);
  localparam int              FRAC_W = SIG_W - 1;
  localparam int              G_IDX  = DBL_FRAC_W - 1 - FRAC_W;
  localparam logic [ES_W-1:0] REBIAS = ES_W'(DBL_BIAS - ((1 << (EXP_W - 1)) - 1));

  logic [DBL_EXP_W-1:0]  dbl_exp;
  logic [DBL_FRAC_W-1:0] dbl_frac;

  logic                  s1_load;
  logic                  s2_load;

  logic                  s1_valid_d, s1_valid_q;
  logic                  sign_d,     sign_q;
  fp_class_e             cls_d,      cls_q;
  logic [ES_W-1:0]       es_d,       es_q;
  logic [FRAC_W-1:0]     frac_d,     frac_q;
  logic                  guard_d,    guard_q;
  logic                  sticky_d,   sticky_q;

  logic                  s2_valid_d, s2_valid_q;
  logic [OUT_W-1:0]      s2_data_d,  s2_data_q;
  logic [2:0]            s2_flags_d, s2_flags_q;

  logic [OUT_W-1:0]      rnd_data;
  logic [2:0]            rnd_flags;

  assign dbl_exp  = in_data[DBL_W-2 -: DBL_EXP_W];
  assign dbl_frac = in_data[DBL_FRAC_W-1:0];

  always_comb begin
    s2_load = !s2_valid_q | out_ready;
    s1_load = !s1_valid_q | s2_load;
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_flags = s2_flags_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    sign_d     = sign_q;
    cls_d      = cls_q;
    es_d       = es_q;
    frac_d     = frac_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        sign_d   = in_data[DBL_W-1];
        es_d     = {{(ES_W-DBL_EXP_W){1'b0}}, dbl_exp} - REBIAS;
        frac_d   = dbl_frac[DBL_FRAC_W-1 -: FRAC_W];
        guard_d  = dbl_frac[G_IDX];
        sticky_d = |dbl_frac[G_IDX-1:0];
        if (dbl_exp == '1) begin
          if (|dbl_frac) begin
            cls_d = NAN;
          end else begin
            cls_d = INF;
          end
        end else if (dbl_exp == '0) begin
          // Double subnormals carry only sticky so the round stage flags exactly when F is nonzero
          cls_d    = ZERO;
          guard_d  = 1'b0;
          sticky_d = |dbl_frac;
        end else begin
          cls_d = NORM;
        end
      end
    end
  end

  rec_fp_round #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_round (
    .sign   (sign_q),
    .cls    (cls_q),
    .es     (es_q),
    .frac   (frac_q),
    .guard  (guard_q),
    .sticky (sticky_q),
    .data   (rnd_data),
    .flags  (rnd_flags)
  );

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = rnd_data;
        s2_flags_d = rnd_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sign_q     <= 1'b0;
      cls_q      <= ZERO;
      es_q       <= '0;
      frac_q     <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flags_q <= 3'b000;
    end else begin
      s1_valid_q <= s1_valid_d;
      sign_q     <= sign_d;
      cls_q      <= cls_d;
      es_q       <= es_d;
      frac_q     <= frac_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
    end
  end

endmodule

// File: tb/tb_dbl_to_rec_fp.sv
// tb/tb_dbl_to_rec_fp.sv - scoreboard bench for dbl_to_rec_fp with a numeric reference model
module tb_dbl_to_rec_fp;

  typedef struct {
    logic [32:0] data;
    logic [2:0]  flags;
    bit          rt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic [2:0]  out_flags;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_out  = 0;
  int   rdy_mode = 1;

  dbl_to_rec_fp #(
    .EXP_W (8),
    .SIG_W (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Numeric model: quotient/remainder rounding on the 52-bit fraction, single-precision target
  function automatic exp_t ref_model(input logic [63:0] d);
    exp_t r;
    longint unsigned f, q, rem, half;
    int e, es;
    r.rt    = 1'b0;
    r.flags = 3'b000;
    r.data  = {d[63], 32'h0};
    e = {21'b0, d[62:52]};
    f = {12'b0, d[51:0]};
    if (e == 2047) begin
      if (f != 0) r.data = {d[63], 9'h1C0, 23'h400000};
      else        r.data = {d[63], 9'h180, 23'h0};
      return r;
    end
    if (e == 0) begin
      r.flags = (f != 0) ? 3'b011 : 3'b000;
      return r;
    end
    es = e - 1023 + 127;
    if (es <= 0) begin
      r.flags = 3'b011;
      return r;
    end
    half = 64'd1 << 28;
    q    = f / (64'd1 << 29);
    rem  = f % (64'd1 << 29);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == (64'd1 << 23)) begin
      q  = 0;
      es = es + 1;
    end
    if (es >= 255) begin
      r.data  = {d[63], 9'h180, 23'h0};
      r.flags = 3'b101;
      return r;
    end
    r.data  = {d[63], 9'(es + 129), 23'(q)};
    r.flags = {2'b00, rem != 0};
    return r;
  endfunction

  function automatic real rec_to_real(input logic [32:0] x);
    real v;
    int  n;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    n = int'(x[31:23]) - 256;
    for (int i = 0; i < n; i++) v = v * 2.0;
    for (int i = 0; i < -n; i++) v = v / 2.0;
    if (x[32]) v = -v;
    return v;
  endfunction

  function automatic exp_t mk(input logic [32:0] d, input logic [2:0] f);
    exp_t r;
    r.data  = d;
    r.flags = f;
    r.rt    = 1'b0;
    return r;
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic        s;
    logic [10:0] e;
    logic [51:0] f;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       e = 11'($urandom_range(0, 2047));
      1:       e = 11'($urandom_range(890, 902));
      2:       e = 11'($urandom_range(1145, 1152));
      3:       e = 11'd0;
      4:       e = 11'd2047;
      default: e = 11'($urandom_range(897, 1149));
    endcase
    f = 52'({$urandom(), $urandom()});
    if ($urandom_range(0, 3) == 0) f[28:0] = 29'h10000000;
    if ($urandom_range(0, 5) == 0) f[51:29] = '1;
    if ($urandom_range(0, 7) == 0) f = '0;
    return {s, e, f};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [63:0] d, input exp_t ex, input int max_idle, output int waits);
    int idle;
    idle = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
    in_valid = 1'b0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b for word %h", in_ready, d);
    end else begin
      sb.push_back(ex);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    logic        held_v;
    logic [32:0] held_d;
    logic [2:0]  held_f;
    exp_t        e;
    real         v, diff;
    held_v = 1'b0;
    held_d = '0;
    held_f = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          n_cmp++;
          if (!out_valid || out_data !== held_d || out_flags !== held_f) begin
            n_fail++;
            $display("FAIL hold: got v=%b %h/%b want v=1 %h/%b", out_valid, out_data, out_flags, held_d, held_f);
          end
        end
        held_v = 1'b0;
        if (out_valid && out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: got %h/%b want no output", out_data, out_flags);
          end else begin
            e = sb.pop_front();
            n_out++;
            if (out_data !== e.data || out_flags !== e.flags) begin
              n_fail++;
              $display("FAIL out[%0d]: got %h flags %b want %h flags %b", n_out, out_data, out_flags, e.data, e.flags);
            end
            if (e.rt) begin
              v    = rec_to_real(out_data);
              diff = v - 1e-15;
              if (diff < 0.0) diff = -diff;
              n_cmp++;
              if (diff >= 1e-20) begin
                n_fail++;
                $display("FAIL roundtrip: got %e want 1e-15 within 1e-20", v);
              end
            end
          end
        end else if (out_valid) begin
          held_v = 1'b1;
          held_d = out_data;
          held_f = out_flags;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t reached with %0d words pending", $time, sb.size());
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] dv [13];
    exp_t        ev [13];
    exp_t        r;
    logic [63:0] w;
    int          waits, tot, k;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    rdy_mode = 1;

    dv[0]  = 64'h3FF0000000000000;  ev[0]  = mk(33'h080000000, 3'b000);
    dv[1]  = 64'h0000000000000000;  ev[1]  = mk(33'h000000000, 3'b000);
    dv[2]  = 64'h8000000000000000;  ev[2]  = mk(33'h100000000, 3'b000);
    dv[3]  = 64'h3FF0000010000000;  ev[3]  = mk(33'h080000000, 3'b001);
    dv[4]  = 64'h3FF0000010000001;  ev[4]  = mk(33'h080000001, 3'b001);
    dv[5]  = 64'h47EFFFFFF0000000;  ev[5]  = mk(33'h0C0000000, 3'b101);
    dv[6]  = $realtobits(1e100);    ev[6]  = mk(33'h0C0000000, 3'b101);
    dv[7]  = 64'hFFF0000000000000;  ev[7]  = mk(33'h1C0000000, 3'b000);
    dv[8]  = 64'h7FF8000000000000;  ev[8]  = mk(33'h0E0400000, 3'b000);
    dv[9]  = $realtobits(1e-40);    ev[9]  = mk(33'h000000000, 3'b011);
    dv[10] = $realtobits(1e-100);   ev[10] = mk(33'h000000000, 3'b011);
    dv[11] = $realtobits(1e-315);   ev[11] = mk(33'h000000000, 3'b011);
    dv[12] = $realtobits(1e-15);    ev[12] = ref_model(dv[12]);
    ev[12].rt = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", {28'b0, out_flags, out_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) send(dv[i], ev[i], 1, waits);
    drain("directed_drain");

    for (int i = 0; i < 60; i++) begin
      w = rand_dbl();
      send(w, ref_model(w), 2, waits);
    end
    drain("random_drain");

    rdy_mode = 0;
    @(posedge clk);
    #1;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      w = rand_dbl();
      send(w, ref_model(w), 0, waits);
      tot += waits;
    end
    check("burst_stall_cycles", 64'(tot), 64'd0);
    drain("burst_drain");

    rdy_mode = 2;
    @(posedge clk);
    #1;
    w = $realtobits(2.5);
    send(w, ref_model(w), 0, waits);
    w = $realtobits(-3.75);
    send(w, ref_model(w), 0, waits);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data", {28'b0, out_flags, out_data}, 64'd0);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    w = $realtobits(-1.5);
    r = ref_model(w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(r);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 10);
    check("post_rst_latency", 64'(k), 64'd2);
    drain("final_drain");

    @(negedge clk);
    check("no_extra_output", 64'(out_valid), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
